switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter: DEBOUNCE_LIMIT, default 250000, number of consecutive clock cycles the synchronized input must differ from the debounced output before that output changes (10 ms at 25 MHz); legal values >= 2.
REQ-002 Port: i_clk  input  1  single system clock; all logic on the rising edge.
REQ-003 Port: i_rst  input  1  synchronous, active-high reset.
REQ-004 Port: i_switch_1  input  1  raw, asynchronous, bouncing push-button/switch level, channel 1.
REQ-005 Port: i_switch_2  input  1  raw, asynchronous, bouncing push-button/switch level, channel 2.
REQ-006 Port: o_switch_1  output  1  debounced level, channel 1; feeds the downstream AND-gate stage.
REQ-007 Port: o_switch_2  output  1  debounced level, channel 2; feeds the downstream AND-gate stage.
REQ-008 Port: o_rise_1 / o_rise_2  output  1 each  one-cycle pulse on a debounced 0->1 transition of the channel.
REQ-009 Port: o_fall_1 / o_fall_2  output  1 each  one-cycle pulse on a debounced 1->0 transition of the channel.
REQ-010 One clock and one reset only; the reset is synchronous and active-high, and the clock and reset ports are i_clk and i_rst.

Function
REQ-011 Both channels SHALL be identical and fully independent; no shared counter or state.
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer (sync_a, sync_b) before any other use.
REQ-013 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_LIMIT) and a 2-state FSM: STABLE and COUNTING.
REQ-014 STABLE: if sync_b == o_switch, the FSM stays in STABLE with the counter at 0.
REQ-015 STABLE: if sync_b != o_switch, the FSM moves to COUNTING and the counter becomes 1.
REQ-016 COUNTING: if sync_b == o_switch, the FSM returns to STABLE, the counter clears to 0, and o_switch is unchanged (glitch rejected).
REQ-017 COUNTING: if sync_b != o_switch and counter < DEBOUNCE_LIMIT-1, the counter increments by 1.
REQ-018 COUNTING: if sync_b != o_switch and counter == DEBOUNCE_LIMIT-1, o_switch takes sync_b, the counter clears to 0, and the FSM returns to STABLE.
REQ-019 The counter SHALL never exceed DEBOUNCE_LIMIT-1 and never wrap.
REQ-020 Latency: for an input that changes before edge k and then stays constant, o_switch SHALL change on edge k+DEBOUNCE_LIMIT+1 and not earlier.
REQ-021 o_rise_n SHALL be 1 only in the cycle immediately after the edge on which o_switch_n goes 0->1; o_fall_n likewise for 1->0. Both are registered.
REQ-022 o_rise_n and o_fall_n SHALL never be asserted together and never for more than one cycle per transition.
REQ-023 Any bounce (a return to the old level) SHALL restart the full DEBOUNCE_LIMIT count.

Reset
REQ-024 With i_rst=1 at a rising edge, all synchronizer flops, counters, o_switch_*, o_rise_* and o_fall_* SHALL be 0 and both FSMs SHALL be in STABLE; this takes priority over all other logic.
REQ-025 Reset asserted mid-count SHALL discard the partial count. After release, an input held high SHALL go through a full debounce from 0 and produce one o_rise pulse.
REQ-026 Exiting reset SHALL produce no o_fall pulse.

Verification (DEBOUNCE_LIMIT=4)
REQ-027 Reset: hold i_rst=1 for 3 cycles with both switches at 1 -> all outputs 0 during reset. Release -> o_switch_1 and o_switch_2 go to 1 on the 6th edge after release, with one o_rise pulse on each channel.
REQ-028 Glitch: i_switch_1 high for 3 cycles, then low -> o_switch_1 stays 0 and no o_rise_1 or o_fall_1 pulse occurs.
REQ-029 Bounce: i_switch_1 toggles every cycle for 6 cycles, then holds 1 -> o_switch_1 goes to 1 exactly on edge k+5 after the final settle, with exactly one o_rise_1 pulse.
REQ-030 Release: i_switch_1 goes from held 1 to held 0 -> o_switch_1 goes to 0 on edge k+5, and o_fall_1 is high for exactly 1 cycle.
REQ-031 Simultaneous: both switches go 0->1 in the same cycle -> both outputs and both rise pulses change in the same cycle. Channel 2 bouncing while channel 1 is stable does not affect channel 1.
REQ-032 Reset mid-count: i_switch_1 goes to 1, then i_rst=1 when the counter is 2, released the next cycle -> o_switch_1 is 0, and it reaches 1 only after a full 6-edge debounce from the release.

Source files
------------

// File: rtl/switch_debounce_if.sv
// Raw switch inputs and debounced outputs for the two-channel debouncer.
// The environment uses the master side and the debouncer uses the slave side.
interface switch_debounce_if;
  logic i_switch_1;
  logic i_switch_2;
  logic o_switch_1;
  logic o_switch_2;
  logic o_rise_1;
  logic o_rise_2;
  logic o_fall_1;
  logic o_fall_2;

  modport master (
    output i_switch_1, i_switch_2,
    input  o_switch_1, o_switch_2, o_rise_1, o_rise_2, o_fall_1, o_fall_2
  );

  modport slave (
    input  i_switch_1, i_switch_2,
    output o_switch_1, o_switch_2, o_rise_1, o_rise_2, o_fall_1, o_fall_2
  );
endinterface

// File: rtl/switch_debounce.sv
// Two independent switch debouncers. Each channel has a 2-flop synchronizer and a
// STABLE/COUNTING FSM, and produces registered rise/fall pulses.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input logic          i_clk,
  input logic          i_rst,
  switch_debounce_if.slave sw
);
  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} state_t;

  logic [1:0] sw_raw;
  logic [1:0] sw_out;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;

  assign sw_raw        = {sw.i_switch_2, sw.i_switch_1};
  assign sw.o_switch_1 = sw_out[0];
  assign sw.o_switch_2 = sw_out[1];
  assign sw.o_rise_1   = sw_rise[0];
  assign sw.o_rise_2   = sw_rise[1];
  assign sw.o_fall_1   = sw_fall[0];
  assign sw.o_fall_2   = sw_fall[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_a_q, sync_a_d;
    logic             sync_b_q, sync_b_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q  <= STABLE;
        cnt_q    <= '0;
        sync_a_q <= 1'b0;
        sync_b_q <= 1'b0;
        out_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        sync_a_q <= sync_a_d;
        sync_b_q <= sync_b_d;
        out_q    <= out_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    // Any return to the old level drops back to STABLE, so a bounce restarts the full count.
    always_comb begin
      sync_a_d = sw_raw[ch];
      sync_b_d = sync_a_q;
      state_d  = state_q;
      cnt_d    = '0;
      out_d    = out_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      case (state_q)
        STABLE: begin
          if (sync_b_q != out_q) begin
            state_d = COUNTING;
            cnt_d   = CNT_W'(1);
          end
        end
        COUNTING: begin
          if (sync_b_q == out_q) begin
            state_d = STABLE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE;
            out_d   = sync_b_q;
            rise_d  = sync_b_q;
            fall_d  = ~sync_b_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = STABLE;
      endcase
    end

    assign sw_out[ch]  = out_q;
    assign sw_rise[ch] = rise_q;
    assign sw_fall[ch] = fall_q;
  end
endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_LIMIT=4: a segment table of per-cycle
// stimulus with hand-derived expected outputs, checked through a one-deep scoreboard.
module tb_switch_debounce;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  switch_debounce_if sw_if ();

  switch_debounce #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .sw    (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rst, sw1, sw2} held for reps cycles; exp = {o1, o2, rise1, rise2, fall1, fall2}
  // after each of those rising edges.
  typedef struct {
    logic       rst;
    logic       s1;
    logic       s2;
    int         reps;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [5:0] outs();
    return {sw_if.o_switch_1, sw_if.o_switch_2, sw_if.o_rise_1,
            sw_if.o_rise_2, sw_if.o_fall_1, sw_if.o_fall_2};
  endfunction

  task automatic add(input logic r, input logic a, input logic b, input int n,
                     input logic [5:0] e);
    vec_t v;
    v.rst = r; v.s1 = a; v.s2 = b; v.reps = n; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check_pending();
    logic [5:0] e;
    logic [5:0] g;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = outs();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL vec%0d outputs{o1,o2,r1,r2,f1,f2}: got %b required %b", n_vec, g, e);
      end
    end
  endtask

  task automatic apply(input logic r, input logic a, input logic b, input logic [5:0] e);
    @(negedge clk);
    check_pending();
    rst = r;
    sw_if.i_switch_1 = a;
    sw_if.i_switch_2 = b;
    sb_q.push_back(e);
  endtask

  task automatic expect_bit(input string name, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  // Pulses must never overlap and never last two cycles.
  logic prev_r1, prev_r2, prev_f1, prev_f2;
  always @(negedge clk) begin
    if (sw_if.o_rise_1 === 1'b1 && sw_if.o_fall_1 === 1'b1) begin
      n_err++; $display("FAIL pulse_overlap_1: rise and fall both 1");
    end
    if (sw_if.o_rise_2 === 1'b1 && sw_if.o_fall_2 === 1'b1) begin
      n_err++; $display("FAIL pulse_overlap_2: rise and fall both 1");
    end
    if ((prev_r1 === 1'b1 && sw_if.o_rise_1 === 1'b1) || (prev_f1 === 1'b1 && sw_if.o_fall_1 === 1'b1) ||
        (prev_r2 === 1'b1 && sw_if.o_rise_2 === 1'b1) || (prev_f2 === 1'b1 && sw_if.o_fall_2 === 1'b1)) begin
      n_err++; $display("FAIL pulse_width: pulse high 2 cycles, required 1");
    end
    prev_r1 = sw_if.o_rise_1; prev_r2 = sw_if.o_rise_2;
    prev_f1 = sw_if.o_fall_1; prev_f2 = sw_if.o_fall_2;
  end

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    sw_if.i_switch_1 = 1'b1;
    sw_if.i_switch_2 = 1'b1;

    // Reset with both switches high, then full debounce from release.
    add(1, 1, 1, 3, 6'b000000);
    add(0, 1, 1, 5, 6'b000000);
    add(0, 1, 1, 1, 6'b111100);
    add(0, 1, 1, 2, 6'b110000);
    // Both released together.
    add(0, 0, 0, 5, 6'b110000);
    add(0, 0, 0, 1, 6'b000011);
    add(0, 0, 0, 1, 6'b000000);
    // Three-cycle glitch on channel 1 is rejected.
    add(0, 1, 0, 3, 6'b000000);
    add(0, 0, 0, 5, 6'b000000);
    // Channel 1 toggles for six cycles, then settles high.
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 0, 1, 6'b000000);
      add(0, 0, 0, 1, 6'b000000);
    end
    add(0, 1, 0, 5, 6'b000000);
    add(0, 1, 0, 1, 6'b101000);
    add(0, 1, 0, 2, 6'b100000);
    // Channel 2 bounces (three-cycle run is one short) while channel 1 holds.
    add(0, 1, 1, 1, 6'b100000);
    add(0, 1, 0, 1, 6'b100000);
    add(0, 1, 1, 3, 6'b100000);
    add(0, 1, 0, 3, 6'b100000);
    // Channel 1 released.
    add(0, 0, 0, 5, 6'b100000);
    add(0, 0, 0, 1, 6'b000010);
    add(0, 0, 0, 1, 6'b000000);
    // Simultaneous rise.
    add(0, 1, 1, 5, 6'b000000);
    add(0, 1, 1, 1, 6'b111100);
    add(0, 1, 1, 1, 6'b110000);
    // Reset while high: no fall pulse on exit.
    add(1, 0, 0, 1, 6'b000000);
    add(0, 0, 0, 3, 6'b000000);
    // Reset with channel 1 counter at 2 discards the count.
    add(0, 1, 0, 4, 6'b000000);
    add(1, 1, 0, 1, 6'b000000);
    add(0, 1, 0, 5, 6'b000000);
    add(0, 1, 0, 1, 6'b101000);
    add(0, 1, 0, 1, 6'b100000);

    foreach (tbl[i])
      for (int j = 0; j < tbl[i].reps; j++)
        apply(tbl[i].rst, tbl[i].s1, tbl[i].s2, tbl[i].exp);
    @(negedge clk);
    check_pending();

    // Release channel 1 and measure edges to the fall pulse, bounded.
    sw_if.i_switch_1 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (sw_if.o_fall_1 === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || n != LIMIT + 2) begin
      n_err++;
      $display("FAIL fall_latency: got %0d edges (seen=%b) required %0d", n, seen, LIMIT + 2);
    end
    expect_bit("o_switch_1_after_fall", sw_if.o_switch_1, 1'b0);
    expect_bit("o_switch_2_unaffected", sw_if.o_switch_2, 1'b0);
    @(negedge clk);
    expect_bit("o_fall_1_one_cycle", sw_if.o_fall_1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
